// File: rtl/minmax_pkg.sv
// Shared constants for the min/max window tracker: FSM state encodings and window default.
package minmax_pkg;

  localparam int unsigned WINDOW_DEFAULT = 8;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/comparator_4bit.sv
// 4-bit magnitude comparator, unsigned or two's-complement selected by sign.
module comparator_4bit (
  input  logic       sign,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       equals,
  output logic       greater_than,
  output logic       less_than
);

  always_comb begin
    equals = (A == B);
    if (sign) begin
      greater_than = ($signed(A) > $signed(B));
      less_than    = ($signed(A) < $signed(B));
    end else begin
      greater_than = (A > B);
      less_than    = (A < B);
    end
  end

endmodule

// File: rtl/minmax_tracker_4bit.sv
// Tracks min/max/range/count over a window of WINDOW samples, holding the result
// until the consumer accepts it.
module minmax_tracker_4bit
  import minmax_pkg::*;
#(
  parameter int unsigned WINDOW = WINDOW_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sign,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] min_val,
  output logic [3:0] max_val,
  output logic [3:0] range,
  output logic [3:0] count
);

  localparam logic [3:0] WIN = 4'(WINDOW);

  logic [1:0] state_q, state_d;
  logic [3:0] min_q, min_d;
  logic [3:0] max_q, max_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sign_q, sign_d;

  logic min_eq, min_gt, min_lt;
  logic max_eq, max_gt, max_lt;
  logic accept;
  logic unused_cmp;

  comparator_4bit u_cmp_min (
    .sign         (sign_q),
    .A            (in_data),
    .B            (min_q),
    .equals       (min_eq),
    .greater_than (min_gt),
    .less_than    (min_lt)
  );

  comparator_4bit u_cmp_max (
    .sign         (sign_q),
    .A            (in_data),
    .B            (max_q),
    .equals       (max_eq),
    .greater_than (max_gt),
    .less_than    (max_lt)
  );

  assign unused_cmp = min_gt ^ max_lt;

  assign in_ready  = (state_q != ST_HOLD);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign min_val   = min_q;
  assign max_val   = max_q;
  assign count     = cnt_q;
  // Modulo-16 subtraction yields the true magnitude in both modes (max >= min).
  assign range     = max_q - min_q;

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    if (clear) begin
      state_d = ST_EMPTY;
      min_d   = '0;
      max_d   = '0;
      cnt_d   = '0;
      sign_d  = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            min_d   = in_data;
            max_d   = in_data;
            cnt_d   = 4'd1;
            sign_d  = sign;
            state_d = (WINDOW == 1) ? ST_HOLD : ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (accept) begin
            if (min_lt && !min_eq) min_d = in_data;
            if (max_gt && !max_eq) max_d = in_data;
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == WIN) state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d = ST_EMPTY;
            min_d   = '0;
            max_d   = '0;
            cnt_d   = '0;
            sign_d  = 1'b0;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      min_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
    end
  end

endmodule

// File: tb/tb_minmax_tracker_4bit.sv
// Directed bench for minmax_tracker_4bit with WINDOW = 8.
module tb_minmax_tracker_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sign;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] min_val;
  logic [3:0] max_val;
  logic [3:0] range;
  logic [3:0] count;

  int n_cmp = 0;
  int n_err = 0;

  minmax_tracker_4bit #(.WINDOW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sign      (sign),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .min_val   (min_val),
    .max_val   (max_val),
    .range     (range),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_window(input logic [3:0] v [8], input logic s);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      sign     = (i == 0) ? s : ~s;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sign = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    n_cmp++;
    if ({in_ready, out_valid, min_val, max_val, range, count} !== {1'b1, 1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL reset: rdy=%b ov=%b min=%h max=%h rng=%h cnt=%h required rdy=1 ov=0 all zero",
               in_ready, out_valid, min_val, max_val, range, count);
    end
  endtask

  task automatic test_unsigned();
    logic [3:0] v [8] = '{4'd3, 4'd9, 4'd1, 4'd9, 4'd4, 4'd12, 4'd0, 4'd5};
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = v[i]; sign = 1'b0;
      step();
      if (i == 6) begin
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 4'd7) begin
          n_err++;
          $display("FAIL unsigned_pre: ov=%b cnt=%0d required ov=0 cnt=7", out_valid, count);
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, min_val, max_val, range, count} !== {1'b1, 1'b0, 4'd0, 4'd12, 4'd12, 4'd8}) begin
      n_err++;
      $display("FAIL unsigned_hold: ov=%b rdy=%b min=%0d max=%0d rng=%0d cnt=%0d required 1 0 0 12 12 8",
               out_valid, in_ready, min_val, max_val, range, count);
    end
    release_result();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL unsigned_release: ov=%b rdy=%b required ov=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_signed();
    logic [3:0] v [8] = '{4'b0111, 4'b1000, 4'b0000, 4'b1111, 4'b0001, 4'b0010, 4'b1110, 4'b0011};
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = v[i]; sign = 1'b1;
      step();
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, min_val, max_val, range} !== {1'b1, 4'b1000, 4'b0111, 4'd15}) begin
      n_err++;
      $display("FAIL signed_hold: ov=%b min=%b max=%b rng=%0d required 1 1000 0111 15",
               out_valid, min_val, max_val, range);
    end
    release_result();
  endtask

  task automatic test_sign_latch();
    logic [3:0] v [8] = '{4'b1111, 4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    send_window(v, 1'b0);
    n_cmp++;
    if ({out_valid, min_val, max_val, range} !== {1'b1, 4'b0001, 4'b1111, 4'd14}) begin
      n_err++;
      $display("FAIL sign_latch: ov=%b min=%b max=%b rng=%0d required 1 0001 1111 14",
               out_valid, min_val, max_val, range);
    end
    release_result();
  endtask

  task automatic test_equal();
    logic [3:0] v [8] = '{default: 4'b0101};
    send_window(v, 1'b0);
    n_cmp++;
    if ({out_valid, min_val, max_val, range, count} !== {1'b1, 4'b0101, 4'b0101, 4'd0, 4'd8}) begin
      n_err++;
      $display("FAIL equal: ov=%b min=%b max=%b rng=%0d cnt=%0d required 1 0101 0101 0 8",
               out_valid, min_val, max_val, range, count);
    end
    release_result();
  endtask

  task automatic test_back_to_back_stall();
    logic [3:0] v [8] = '{4'd2, 4'd14, 4'd7, 4'd7, 4'd3, 4'd11, 4'd6, 4'd9};
    send_window(v, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({out_valid, in_ready, min_val, max_val, range, count} !== {1'b1, 1'b0, 4'd2, 4'd14, 4'd12, 4'd8}) begin
        n_err++;
        $display("FAIL stall[%0d]: ov=%b rdy=%b min=%0d max=%0d rng=%0d cnt=%0d required 1 0 2 14 12 8",
                 i, out_valid, in_ready, min_val, max_val, range, count);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 4'd0) begin
      n_err++;
      $display("FAIL stall_release: ov=%b rdy=%b cnt=%0d required ov=0 rdy=1 cnt=0", out_valid, in_ready, count);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_clear();
    logic [3:0] pre [3] = '{4'd5, 4'd6, 4'd7};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = pre[i]; sign = 1'b0;
      step();
    end
    clear = 1'b1; in_valid = 1'b1; in_data = 4'd2;
    step();
    clear = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, min_val, max_val, range, count} !== {1'b0, 1'b1, 16'h0000}) begin
      n_err++;
      $display("FAIL clear: ov=%b rdy=%b min=%0d max=%0d rng=%0d cnt=%0d required ov=0 rdy=1 all zero",
               out_valid, in_ready, min_val, max_val, range, count);
    end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 4'(i + 4);
      step();
      if (i == 6) begin
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 4'd7) begin
          n_err++;
          $display("FAIL clear_recount: ov=%b cnt=%0d required ov=0 cnt=7", out_valid, count);
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, min_val, max_val, count} !== {1'b1, 4'd4, 4'd11, 4'd8}) begin
      n_err++;
      $display("FAIL clear_window: ov=%b min=%0d max=%0d cnt=%0d required 1 4 11 8",
               out_valid, min_val, max_val, count);
    end
    release_result();
  endtask

  task automatic test_reset_in_hold();
    logic [3:0] v [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    send_window(v, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_hold_pre: ov=%b required 1", out_valid);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if ({out_valid, in_ready, min_val, max_val, range, count} !== {1'b0, 1'b1, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_hold: ov=%b rdy=%b min=%0d max=%0d rng=%0d cnt=%0d required ov=0 rdy=1 all zero",
               out_valid, in_ready, min_val, max_val, range, count);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold_after: ov=%b required 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_sign_latch();
    test_equal();
    test_back_to_back_stall();
    test_clear();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
